nbbpu_memory: RTL

Memory-side responder for the NBBPU bus. It answers the CPU's instruction fetch (PC → instruction) and data accesses (data_address/data_out/data_write → data_in). A byte-stream loader fills instruction memory after reset, and the block holds the CPU in reset until the program is loaded.

---
 rtl/nbbpu_memory_pkg.sv | 13 +
 rtl/nbbpu_loader.sv | 93 +++++++++
 rtl/nbbpu_memory.sv | 98 +++++++++
 3 files changed

// File: rtl/nbbpu_memory_pkg.sv
// Shared types and constants for the NBBPU memory responder.
package nbbpu_memory_pkg;

  localparam int WORD_W = 16;
  localparam logic [WORD_W-1:0] MMIO_LEDS_ADDR = 16'hFFFF;

  typedef enum logic [1:0] {
    LOAD_LO = 2'd0,
    LOAD_HI = 2'd1,
    RUN     = 2'd2
  } state_t;

endpackage

// File: rtl/nbbpu_loader.sv
// Byte-stream program loader: pairs little-endian bytes into instruction words
// and reports when the program is in place so the CPU may leave reset.
module nbbpu_loader
  import nbbpu_memory_pkg::*;
#(
  parameter int IA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_valid,
  input  logic [7:0]        load_byte,
  input  logic              load_last,
  output logic              load_ready,
  output logic              load_done,
  output logic              wr_en,
  output logic [IA_W-1:0]   wr_addr,
  output logic [WORD_W-1:0] wr_data,
  output state_t            state
);

  localparam logic [IA_W-1:0] ADDR_MAX = '1;

  // Handshake: a byte transfers on any rising edge where load_valid and
  // load_ready are both high; load_ready never depends on load_valid.
  logic            handshake;
  logic [IA_W-1:0] load_addr;
  logic [7:0]      low_byte;

  assign handshake = load_valid & load_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= LOAD_LO;
      load_addr  <= '0;
      low_byte   <= '0;
      load_ready <= 1'b1;
      load_done  <= 1'b0;
    end else begin
      case (state)
        LOAD_LO: begin
          if (handshake) begin
            if (load_last) begin
              state      <= RUN;
              load_ready <= 1'b0;
              load_done  <= 1'b1;
            end else begin
              low_byte <= load_byte;
              state    <= LOAD_HI;
            end
          end
        end
        LOAD_HI: begin
          if (handshake) begin
            load_addr <= load_addr + 1'b1;
            // The last word slot closes the load; nothing ever wraps to word 0.
            if (load_last || (load_addr == ADDR_MAX)) begin
              state      <= RUN;
              load_ready <= 1'b0;
              load_done  <= 1'b1;
            end else begin
              state <= LOAD_LO;
            end
          end
        end
        RUN: begin
          state <= RUN;
        end
        default: begin
          state      <= LOAD_LO;
          load_ready <= 1'b1;
          load_done  <= 1'b0;
        end
      endcase
    end
  end

  // The word write is combinational so the final word lands on the same edge
  // that moves to RUN, ready for the CPU's first fetch.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = load_addr;
    wr_data = {8'h00, load_byte};
    if (handshake) begin
      if (state == LOAD_HI) begin
        wr_en   = 1'b1;
        wr_data = {load_byte, low_byte};
      end else if ((state == LOAD_LO) && load_last) begin
        wr_en = 1'b1;
      end
    end
  end

endmodule

// File: rtl/nbbpu_memory.sv
// NBBPU memory responder: zero-latency instruction/data memories, program
// loader and optional LED register (enabled by NBBPU_MEMORY_MMIO_EN).
module nbbpu_memory
  import nbbpu_memory_pkg::*;
#(
  parameter int INSTR_DEPTH = 256,
  parameter int DATA_DEPTH  = 256
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_valid,
  input  logic [7:0]        load_byte,
  input  logic              load_last,
  output logic              load_ready,
  output logic              load_done,
  output logic              cpu_reset,
  input  logic [15:0]       PC,
  output logic [WORD_W-1:0] instruction,
  input  logic [15:0]       data_address,
  input  logic [WORD_W-1:0] data_out,
  input  logic              data_write,
  output logic [WORD_W-1:0] data_in,
  output logic [WORD_W-1:0] leds
);

  localparam int IA_W = $clog2(INSTR_DEPTH);
  localparam int DA_W = $clog2(DATA_DEPTH);

  logic [WORD_W-1:0] instr_mem [INSTR_DEPTH];
  logic [WORD_W-1:0] data_mem  [DATA_DEPTH];

  logic              wr_en;
  logic [IA_W-1:0]   wr_addr;
  logic [WORD_W-1:0] wr_data;
  state_t            state;
  logic              running;
  logic              mem_write;
  logic [DA_W-1:0]   data_index;
  logic              unused_bits;

  nbbpu_loader #(
    .IA_W (IA_W)
  ) u_loader (
    .clock      (clock),
    .reset      (reset),
    .load_valid (load_valid),
    .load_byte  (load_byte),
    .load_last  (load_last),
    .load_ready (load_ready),
    .load_done  (load_done),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .state      (state)
  );

  assign running    = (state == RUN);
  assign cpu_reset  = ~running;
  assign data_index = data_address[DA_W-1:0];

  // Upper address bits are deliberately ignored so addresses wrap.
  assign unused_bits = ^{PC, data_address};

  always_ff @(posedge clock) begin
    if (wr_en) begin
      instr_mem[wr_addr] <= wr_data;
    end
  end

  assign instruction = instr_mem[PC[IA_W-1:0]];

`ifdef NBBPU_MEMORY_MMIO_EN
  logic mmio_hit;
  assign mmio_hit  = (data_address == MMIO_LEDS_ADDR);
  assign mem_write = data_write & running & ~mmio_hit;

  always_ff @(posedge clock) begin
    if (reset) begin
      leds <= '0;
    end else if (data_write && running && mmio_hit) begin
      leds <= data_out;
    end
  end

  assign data_in = mmio_hit ? leds : data_mem[data_index];
`else
  assign mem_write = data_write & running;
  assign leds      = '0;
  assign data_in   = data_mem[data_index];
`endif

  always_ff @(posedge clock) begin
    if (mem_write) begin
      data_mem[data_index] <= data_out;
    end
  end

endmodule
